// File: rtl/seq_logic_unit.sv
// seq_logic_unit: small sequential ALU. Single-cycle arithmetic, logic and
// shift ops complete on the accepting edge. Unsigned MUL (shift-add) and DIV
// (restoring) run one step per clock for WIDTH clocks.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      op request, accepted only while busy = 0
//   op[3:0]    opcode, sampled with start
//   a, b       operands (b is also the shift amount), sampled with start
//   busy       multi-cycle op in progress
//   done       one-cycle pulse: result words and flags were just updated
//   result_lo  low result word (quotient for DIV)
//   result_hi  high result word (MUL high product, DIV remainder, SHL spill)
//   flags      {z, n, c, v}
module seq_logic_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags
);

  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_INC = 4'h2,
                         OP_DEC = 4'h3, OP_MUL = 4'h4, OP_DIV = 4'h5,
                         OP_SHR = 4'h6, OP_SHL = 4'h7, OP_AND = 4'h8,
                         OP_OR  = 4'h9, OP_XOR = 4'hA, OP_NOT = 4'hB,
                         OP_ASR = 4'hC;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic             run_div;
  // acc_hi/acc_lo: MUL {partial product, multiplier}; DIV {remainder, dividend/quotient}
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;

  assign busy = (state == S_RUN);

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH:0]         add_ext, sub_ext, inc_ext, shr_ext;
  logic signed [WIDTH:0]  asr_ext;
  logic [2*WIDTH-1:0]     shl_ext;
  logic [WIDTH-1:0]       dec_val;

  assign add_ext = {1'b0, a} + {1'b0, b};
  assign sub_ext = {1'b0, a} - {1'b0, b};
  assign inc_ext = {1'b0, b} + (WIDTH+1)'(1);
  assign dec_val = b - WIDTH'(1);
  // A guard bit below the operand catches the last bit shifted out; shifts by
  // the full b naturally saturate to 0 (or sign copies) for large amounts.
  assign shr_ext = {a, 1'b0} >> b;
  assign asr_ext = $signed({a, 1'b0}) >>> b;
  assign shl_ext = {{WIDTH{1'b0}}, a} << b;

  logic [WIDTH-1:0] sc_lo, sc_hi;
  logic             sc_c, sc_v, sc_write, go_run;

  // NOTE: every signal assigned in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sc_lo    = '0;
    sc_hi    = '0;
    sc_c     = 1'b0;
    sc_v     = 1'b0;
    sc_write = 1'b1;
    go_run   = 1'b0;
    case (op)
      OP_ADD: begin
        sc_lo = add_ext[M:0];
        sc_c  = add_ext[WIDTH];
        sc_v  = (a[M] == b[M]) && (add_ext[M] != a[M]);
      end
      OP_SUB: begin
        sc_lo = sub_ext[M:0];
        sc_c  = sub_ext[WIDTH];
        sc_v  = (a[M] != b[M]) && (sub_ext[M] != a[M]);
      end
      OP_INC: begin
        sc_lo = inc_ext[M:0];
        sc_c  = inc_ext[WIDTH];
      end
      OP_DEC: begin
        sc_lo = dec_val;
        sc_c  = (b == '0);
      end
      OP_MUL: begin
        sc_write = 1'b0;
        go_run   = 1'b1;
      end
      OP_DIV: begin
        if (b == '0) begin
          sc_lo = '1;
          sc_hi = a;
          sc_v  = 1'b1;
        end else begin
          sc_write = 1'b0;
          go_run   = 1'b1;
        end
      end
      OP_SHR: begin
        sc_lo = shr_ext[WIDTH:1];
        sc_c  = shr_ext[0];
      end
      OP_SHL: begin
        sc_lo = shl_ext[M:0];
        sc_hi = shl_ext[2*WIDTH-1:WIDTH];
        sc_c  = (shl_ext[2*WIDTH-1:WIDTH] != '0);
      end
      OP_AND: sc_lo = a & b;
      OP_OR:  sc_lo = a | b;
      OP_XOR: sc_lo = a ^ b;
      OP_NOT: sc_lo = ~b;
      OP_ASR: begin
        sc_lo = asr_ext[WIDTH:1];
        sc_c  = asr_ext[0];
      end
      default: sc_write = 1'b0;  // NOP: outputs hold
    endcase
  end

  // ---------------- iterative MUL / DIV step ----------------
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff, step_hi, step_lo;
  logic             div_ge;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign div_shift = {acc_hi, acc_lo[M]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  // When div_ge holds, div_shift < 2*opnd so the difference fits in WIDTH bits.
  assign div_diff  = WIDTH'(div_shift - {1'b0, opnd});

  assign step_hi = run_div ? (div_ge ? div_diff : div_shift[M:0]) : mul_sum[WIDTH:1];
  assign step_lo = run_div ? {acc_lo[M-1:0], div_ge} : {mul_sum[0], acc_lo[M:1]};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      run_div   <= 1'b0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      opnd      <= '0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      flags     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            done <= !go_run;
            if (sc_write) begin
              result_lo <= sc_lo;
              result_hi <= sc_hi;
              flags     <= {(sc_lo == '0), sc_lo[M], sc_c, sc_v};
            end
            if (go_run) begin
              state   <= S_RUN;
              cnt     <= '0;
              run_div <= (op == OP_DIV);
              opnd    <= b;
              acc_lo  <= a;
              acc_hi  <= '0;
            end
          end
        end
        S_RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_STEP) begin
            state     <= S_IDLE;
            cnt       <= '0;
            done      <= 1'b1;
            result_lo <= step_lo;
            result_hi <= step_hi;
            flags     <= {(step_lo == '0), step_lo[M], (!run_div && step_hi != '0), 1'b0};
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_logic_unit.sv
module tb_seq_logic_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = '0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done;
  logic [15:0] result_lo, result_hi;
  logic [3:0]  flags;

  int n_tests = 0;
  int n_fail  = 0;

  seq_logic_unit #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [15:0] a, b;
    logic [15:0] lo, hi;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] lo, hi;
    logic [3:0]  fl;
    int          lat;
    bit          upd;
  } res_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op and wait (bounded) for done; lat = edges after the accepting edge.
  task automatic run_op(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv,
                        output int lat, output logic ok);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    ok = done;
  endtask

  // Reference model straight from the opcode definitions, using wide integers.
  function automatic res_t model(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv);
    res_t   r;
    longint ua = longint'(av), ub = longint'(bv);
    longint sa = longint'($signed(av)), sb = longint'($signed(bv));
    longint t;
    logic [63:0] w;
    bit c = 0, v = 0;
    r.lo = '0; r.hi = '0; r.lat = 0; r.upd = 1;
    case (o)
      4'h0: begin t = ua + ub; w = t; r.lo = w[15:0]; c = t > 65535;
              t = sa + sb; v = (t > 32767) || (t < -32768); end
      4'h1: begin w = ua - ub; r.lo = w[15:0]; c = ua < ub;
              t = sa - sb; v = (t > 32767) || (t < -32768); end
      4'h2: begin t = ub + 1; w = t; r.lo = w[15:0]; c = t > 65535; end
      4'h3: begin w = ub - 1; r.lo = w[15:0]; c = (ub == 0); end
      4'h4: begin w = ua * ub; r.lo = w[15:0]; r.hi = w[31:16]; c = (r.hi != 0); r.lat = 16; end
      4'h5: if (ub == 0) begin r.lo = 16'hFFFF; r.hi = av; v = 1; end
            else begin w = ua / ub; r.lo = w[15:0]; w = ua % ub; r.hi = w[15:0]; r.lat = 16; end
      4'h6: begin
              w = (ub >= 16) ? 0 : (ua >> ub); r.lo = w[15:0];
              if (ub >= 1 && ub <= 16) begin w = ua >> (ub - 1); c = w[0]; end
            end
      4'h7: begin w = (ub >= 32) ? 0 : (ua << ub); r.lo = w[15:0]; r.hi = w[31:16]; c = (r.hi != 0); end
      4'h8: r.lo = av & bv;
      4'h9: r.lo = av | bv;
      4'hA: r.lo = av ^ bv;
      4'hB: r.lo = ~bv;
      4'hC: if (ub >= 16) begin r.lo = (sa < 0) ? 16'hFFFF : 16'h0; c = (sa < 0); end
            else begin
              w = sa >>> ub; r.lo = w[15:0];
              if (ub != 0) begin w = sa >>> (ub - 1); c = w[0]; end
            end
      default: r.upd = 0;
    endcase
    r.fl = {(r.lo == 0), r.lo[15], c, v};
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    int          lat, busy_cnt, done_cnt;
    logic        ok;
    res_t        m;
    logic [15:0] exp_lo, exp_hi;
    logic [3:0]  exp_fl;

    tbl.push_back('{"add_wrap",  4'h0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b1010, 0});
    tbl.push_back('{"sub_ovf",   4'h1, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 4'b0001, 0});
    tbl.push_back('{"mul",       4'h4, 16'h1234, 16'h5678, 16'h0060, 16'h0626, 4'b0010, 16});
    tbl.push_back('{"div",       4'h5, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 4'b0000, 16});
    tbl.push_back('{"div_zero",  4'h5, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 4'b0101, 0});
    tbl.push_back('{"shl",       4'h7, 16'h8001, 16'h0001, 16'h0002, 16'h0001, 4'b0010, 0});
    tbl.push_back('{"shr_big",   4'h6, 16'h8001, 16'h0014, 16'h0000, 16'h0000, 4'b1000, 0});
    tbl.push_back('{"asr",       4'hC, 16'h8000, 16'h0004, 16'hF800, 16'h0000, 4'b0100, 0});
    tbl.push_back('{"nop_hold",  4'hD, 16'h5555, 16'hAAAA, 16'hF800, 16'h0000, 4'b0100, 0});
    tbl.push_back('{"inc_wrap",  4'h2, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 4'b1010, 0});
    tbl.push_back('{"dec_zero",  4'h3, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 4'b0110, 0});
    tbl.push_back('{"shl_32",    4'h7, 16'h1234, 16'h0020, 16'h0000, 16'h0000, 4'b1000, 0});
    tbl.push_back('{"asr_16",    4'hC, 16'h8001, 16'h0010, 16'hFFFF, 16'h0000, 4'b0110, 0});
    tbl.push_back('{"shr_16",    4'h6, 16'h8001, 16'h0010, 16'h0000, 16'h0000, 4'b1010, 0});
    tbl.push_back('{"not",       4'hB, 16'h0000, 16'h00FF, 16'hFF00, 16'h0000, 4'b0100, 0});
    tbl.push_back('{"xor",       4'hA, 16'hF0F0, 16'hFF00, 16'h0FF0, 16'h0000, 4'b0000, 0});
    tbl.push_back('{"mul_max",   4'h4, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0010, 16});
    tbl.push_back('{"div_by1",   4'h5, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 4'b0100, 16});

    // Reset state, then first start on the first edge after release.
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_lo", result_lo, 0);
    check("rst_hi", result_hi, 0);
    check("rst_flags", flags, 0);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1; op = 4'h0; a = 16'h0007; b = 16'h0008;
    @(posedge clk); #1;
    start = 1'b0;
    check("first_start_done", done, 1);
    check("first_start_lo", result_lo, 16'h000F);

    // Table-driven directed vectors (issued back to back).
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, ok);
      check({tbl[i].name, "_done"}, ok, 1);
      check({tbl[i].name, "_lat"}, lat, tbl[i].lat);
      check({tbl[i].name, "_lo"}, result_lo, tbl[i].lo);
      check({tbl[i].name, "_hi"}, result_hi, tbl[i].hi);
      check({tbl[i].name, "_flags"}, flags, tbl[i].fl);
    end

    // Randomized ops against the reference model.
    exp_lo = tbl[tbl.size()-1].lo;
    exp_hi = tbl[tbl.size()-1].hi;
    exp_fl = tbl[tbl.size()-1].fl;
    for (int i = 0; i < 150; i++) begin
      logic [3:0]  ro;
      logic [15:0] ra, rb;
      ro = 4'($urandom_range(0, 15));
      ra = 16'($urandom);
      rb = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 40)) : 16'($urandom);
      m = model(ro, ra, rb);
      if (m.upd) begin exp_lo = m.lo; exp_hi = m.hi; exp_fl = m.fl; end
      run_op(ro, ra, rb, lat, ok);
      check($sformatf("rnd%0d_op%0h_done", i, ro), ok, 1);
      check($sformatf("rnd%0d_op%0h_lat", i, ro), lat, m.lat);
      check($sformatf("rnd%0d_op%0h_lo", i, ro), result_lo, exp_lo);
      check($sformatf("rnd%0d_op%0h_hi", i, ro), result_hi, exp_hi);
      check($sformatf("rnd%0d_op%0h_flags", i, ro), flags, exp_fl);
    end

    // MUL with a start pulse mid-run: must be ignored; busy for exactly 16 cycles.
    @(negedge clk);
    start = 1'b1; op = 4'h4; a = 16'h1234; b = 16'h5678;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = 0; lat = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      if (lat == 5) begin start = 1'b1; op = 4'h0; a = 16'h0001; b = 16'h0001; end
      if (lat == 6) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check("mid_done", done, 1);
    check("mid_lat", lat, 16);
    check("mid_busy_cycles", busy_cnt, 16);
    check("mid_lo", result_lo, 16'h0060);
    check("mid_hi", result_hi, 16'h0626);
    check("mid_flags", flags, 4'b0010);
    @(posedge clk); #1;
    check("mid_no_extra_done", done, 0);

    // Reset at cycle 5 of a MUL: immediate clear, no done after release.
    @(negedge clk);
    start = 1'b1; op = 4'h4; a = 16'h00FF; b = 16'h00FF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_lo", result_lo, 0);
    check("abort_hi", result_hi, 0);
    check("abort_flags", flags, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    run_op(4'h0, 16'h0002, 16'h0003, lat, ok);
    check("post_abort_done", ok, 1);
    check("post_abort_lo", result_lo, 16'h0005);
    check("post_abort_flags", flags, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_logic_unit.md
SEQ_LOGIC_UNIT -- requirements
Module: seq_logic_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width; legal values are even and at least 4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  op request; accepted only when busy=0.
REQ-005 SHALL have port op  input  4  opcode, sampled with start.
REQ-006 SHALL have port a  input  WIDTH  operand A, sampled with start.
REQ-007 SHALL have port b  input  WIDTH  operand B / shift amount, sampled with start.
REQ-008 SHALL have port busy  output  1  multi-cycle op in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse: result and flags updated.
REQ-010 SHALL have port result_lo  output  WIDTH  low result word, registered.
REQ-011 SHALL have port result_hi  output  WIDTH  high result word, registered.
REQ-012 SHALL have port flags  output  4  registered {z,n,c,v}, bit 3 = z.

Function
REQ-013 SHALL decode opcodes as: 0 ADD a+b; 1 SUB a-b; 2 INC b+1; 3 DEC b-1; 4 MUL unsigned a*b; 5 DIV unsigned a/b; 6 SHR logical a>>b; 7 SHL a<<b; 8 AND; 9 OR; A XOR; B NOT b; C ASR a>>>b; D-F NOP.
REQ-014 SHALL implement a two-state FSM, IDLE and RUN; busy=1 exactly in RUN.
REQ-015 Single-cycle ops (all except MUL, DIV with b!=0) SHALL write result and flags on the accepting edge and assert done for the following cycle.
REQ-016 MUL and DIV with b!=0 SHALL enter RUN, perform one shift-add / restoring-subtract step per cycle with a WIDTH-step counter, write results and pulse done exactly WIDTH edges after the accepting edge, then return to IDLE.
REQ-017 start while busy=1 SHALL be ignored, with no effect on operands, state or outputs.
REQ-018 start in the same cycle as done (FSM back in IDLE) SHALL be accepted, giving back-to-back ops.
REQ-019 result_hi SHALL be: MUL high product word; DIV remainder; SHL bits shifted beyond the low word (the 2*WIDTH shift); 0 for all other ops.
REQ-020 DIV SHALL place the quotient in result_lo.
REQ-021 DIV with b=0 SHALL complete in one cycle with result_lo all ones, result_hi=a, v=1.
REQ-022 Shift amounts SHALL use all of b: SHR amt>=WIDTH gives 0; SHL amt>=2*WIDTH gives 0 in both words; ASR amt>=WIDTH gives all copies of a's MSB.
REQ-023 z SHALL be (result_lo==0); n SHALL be result_lo MSB.
REQ-024 c SHALL be: ADD/INC carry out; SUB/DEC borrow (a<b, or b==0 for DEC); MUL/SHL (result_hi!=0); SHR/ASR last bit shifted out, 0 for amt 0, sign bit for ASR amt>=WIDTH; else 0.
REQ-025 v SHALL be: ADD/SUB two's-complement signed overflow; DIV divide-by-zero; else 0.
REQ-026 NOP SHALL pulse done after one edge and leave result_lo, result_hi and flags unchanged.
REQ-027 Outputs SHALL change only on done-producing edges or reset; intermediate MUL/DIV state SHALL be internal.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, counter 0, busy=0, done=0, result_lo=0, result_hi=0, flags=0.
REQ-029 Reset during RUN SHALL abort the op; no done SHALL follow for it after release.
REQ-030 The first start SHALL be accepted on the first rising edge with rst_n=1.

Verification (WIDTH=16)
REQ-031 ADD a=FFFF b=0001 -> done next cycle; lo=0000 hi=0000; z=1 n=0 c=1 v=0.
REQ-032 SUB a=8000 b=0001 -> lo=7FFF; z=0 n=0 c=0 v=1.
REQ-033 MUL a=1234 b=5678 -> busy high 16 cycles, done 16 edges after accept; hi=0626 lo=0060; c=1; start pulsed mid-run ignored.
REQ-034 DIV a=0064 b=0007 -> after 16 edges lo=000E hi=0002; then DIV a=1234 b=0000 -> done after 1 edge, lo=FFFF hi=1234 v=1.
REQ-035 SHL a=8001 b=0001 -> lo=0002 hi=0001 c=1; SHR a=8001 b=0014 -> lo=0000 z=1 c=0; ASR a=8000 b=0004 -> lo=F800.
REQ-036 rst_n low at cycle 5 of a MUL -> busy/done/results/flags 0 at once; no done after release; next ADD 0002+0003 -> lo=0005.
